// File: rtl/rll_key_pkg.sv
// ---------------------------------------------------------------------------
// rll_key_pkg
// Shared definitions for the RLL32 key loader: default widths, the CRC-8
// polynomial, the decoy key and the loader state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package rll_key_pkg;

   localparam int          KEY_W_DEF     = 32;
   localparam int          CRC_W_DEF     = 8;
   localparam logic [7:0]  CRC_POLY_DEF  = 8'h07;
   localparam logic [31:0] DECOY_KEY_DEF = 32'h0000_0000;
   localparam int          FRAME_LEN_DEF = KEY_W_DEF + CRC_W_DEF;

   // Loader states. Explicit codes keep the encoding stable across tools.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

endpackage : rll_key_pkg

// File: rtl/rll_crc8_serial.sv
// ---------------------------------------------------------------------------
// rll_crc8_serial
// Bit-serial CRC register: MSB-first, init 0, no reflection, no final XOR.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (clears the CRC)
//   clr    in   synchronous clear to 0 (has priority over en)
//   en     in   absorb one data bit this cycle
//   d      in   data bit
//   crc    out  current CRC remainder (registered)
// ---------------------------------------------------------------------------
module rll_crc8_serial
   import rll_key_pkg::*;
#(
   parameter int             W    = CRC_W_DEF,
   parameter logic [W-1:0]   POLY = CRC_POLY_DEF
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic         d,
   output logic [W-1:0] crc
);

   logic [W-1:0] crc_r;

   // One LFSR step: feedback is the outgoing MSB XOR the incoming bit.
   function automatic logic [W-1:0] crc_step(input logic [W-1:0] cur, input logic bit_in);
      logic fb;
      fb       = cur[W-1] ^ bit_in;
      crc_step = {cur[W-2:0], 1'b0} ^ (fb ? POLY : {W{1'b0}});
   endfunction

   // CRC state register: clear wins over update, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_r <= {W{1'b0}};
      end else if (clr) begin
         crc_r <= {W{1'b0}};
      end else if (en) begin
         crc_r <= crc_step(crc_r, d);
      end else begin
         crc_r <= crc_r;
      end
   end

   assign crc = crc_r;

endmodule : rll_crc8_serial

// File: rtl/rll_key_loader.sv
// ---------------------------------------------------------------------------
// rll_key_loader
// Serially receives a key followed by its CRC, checks the CRC and only then
// commits the key to a held parallel bus feeding keyIn_0_0..keyIn_0_31 of
// the locked netlist. Until a good commit, and after any failure, the bus
// carries the decoy key, so a partial or corrupted key is never visible.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse starting a load (IDLE/DONE/ERROR only)
//   ser_valid  in   serial bit valid
//   ser_data   in   serial bit, key MSB first then CRC MSB first
//   ser_ready  out  high only while shifting; transfer = valid & ready
//   key_out    out  committed key, bit i drives keyIn_0_i
//   key_valid  out  high while key_out holds a CRC-checked key
//   busy       out  high while shifting or checking
//   crc_err    out  sticky CRC mismatch flag, cleared by start or reset
// ---------------------------------------------------------------------------
module rll_key_loader
   import rll_key_pkg::*;
#(
   parameter int               KEY_W     = KEY_W_DEF,
   parameter int               CRC_W     = CRC_W_DEF,
   parameter logic [CRC_W-1:0] CRC_POLY  = CRC_POLY_DEF,
   parameter logic [KEY_W-1:0] DECOY_KEY = DECOY_KEY_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             ser_valid,
   input  logic             ser_data,
   output logic             ser_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             busy,
   output logic             crc_err
);

   localparam int FRAME_LEN = KEY_W + CRC_W;
   localparam int CNT_W     = $clog2(FRAME_LEN);

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_KEY_N = CNT_W'(KEY_W);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [KEY_W-1:0] sr_r;
   logic [CRC_W-1:0] rx_r;
   logic [KEY_W-1:0] key_out_r;
   logic             key_valid_r;
   logic             busy_r;
   logic             crc_err_r;
   logic             ser_ready_r;

   logic             crc_clr_s;
   logic             crc_en_s;
   logic [CRC_W-1:0] crc_s;

   // CRC control: clear on an accepted start, absorb only key-bit transfers.
   always_comb begin
      crc_clr_s = 1'b0;
      crc_en_s  = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            crc_clr_s = start;
            crc_en_s  = 1'b0;
         end
         ST_SHIFT: begin
            crc_clr_s = 1'b0;
            crc_en_s  = ser_valid & ser_ready_r & (cnt_r < CNT_KEY_N);
         end
         default: begin
            crc_clr_s = 1'b0;
            crc_en_s  = 1'b0;
         end
      endcase
   end

   rll_crc8_serial #(
      .W    (CRC_W),
      .POLY (CRC_POLY)
   ) u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (crc_clr_s),
      .en    (crc_en_s),
      .d     (ser_data),
      .crc   (crc_s)
   );

   // Loader FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         sr_r        <= {KEY_W{1'b0}};
         rx_r        <= {CRC_W{1'b0}};
         key_out_r   <= DECOY_KEY;
         key_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         crc_err_r   <= 1'b0;
         ser_ready_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  // A reload hides the previous key from the very next cycle.
                  state_r     <= ST_SHIFT;
                  cnt_r       <= CNT_ZERO;
                  sr_r        <= {KEY_W{1'b0}};
                  rx_r        <= {CRC_W{1'b0}};
                  key_out_r   <= DECOY_KEY;
                  key_valid_r <= 1'b0;
                  busy_r      <= 1'b1;
                  crc_err_r   <= 1'b0;
                  ser_ready_r <= 1'b1;
               end
            end

            ST_SHIFT: begin
               if (ser_valid && ser_ready_r) begin
                  if (cnt_r < CNT_KEY_N) begin
                     sr_r <= {sr_r[KEY_W-2:0], ser_data};
                  end else begin
                     rx_r <= {rx_r[CRC_W-2:0], ser_data};
                  end
                  if (cnt_r == CNT_LAST) begin
                     // ready drops together with the move to CHECK.
                     state_r     <= ST_CHECK;
                     cnt_r       <= CNT_ZERO;
                     ser_ready_r <= 1'b0;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end

            ST_CHECK: begin
               busy_r <= 1'b0;
               if (crc_s == rx_r) begin
                  state_r     <= ST_DONE;
                  key_out_r   <= sr_r;
                  key_valid_r <= 1'b1;
               end else begin
                  state_r     <= ST_ERROR;
                  crc_err_r   <= 1'b1;
                  key_out_r   <= DECOY_KEY;
                  key_valid_r <= 1'b0;
               end
            end

            default: begin
               // Illegal state: fall back to the safe decoy configuration.
               state_r     <= ST_IDLE;
               cnt_r       <= CNT_ZERO;
               key_out_r   <= DECOY_KEY;
               key_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               ser_ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign ser_ready = ser_ready_r;
   assign key_out   = key_out_r;
   assign key_valid = key_valid_r;
   assign busy      = busy_r;
   assign crc_err   = crc_err_r;

endmodule : rll_key_loader

// File: tb/tb_rll_key_loader.sv
// ---------------------------------------------------------------------------
// tb_rll_key_loader
// Self-checking bench for rll_key_loader. Expected CRCs come from polynomial
// long division of the 40-bit value {key, 8'h00} by x^8+x^2+x+1.
// ---------------------------------------------------------------------------
module tb_rll_key_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        ser_valid;
   logic        ser_data;
   logic        ser_ready;
   logic [31:0] key_out;
   logic        key_valid;
   logic        busy;
   logic        crc_err;

   int err_cnt;
   int chk_cnt;

   rll_key_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ser_valid (ser_valid),
      .ser_data  (ser_data),
      .ser_ready (ser_ready),
      .key_out   (key_out),
      .key_valid (key_valid),
      .busy      (busy),
      .crc_err   (crc_err)
   );

   // 100 MHz free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point for the whole bench.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference CRC-8 by long division of key * x^8 by the 9-bit polynomial 0x107.
   function automatic logic [7:0] ref_crc(input logic [31:0] key);
      logic [39:0] v;
      v = {key, 8'h00};
      for (int i = 39; i >= 8; i--) begin
         if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
      end
      return v[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start from IDLE/DONE/ERROR and check the old key is hidden at once.
   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("start_key_hidden", key_out, 32'h0);
      check_eq("start_valid_low", {31'h0, key_valid}, 32'h0);
      check_eq("start_err_clear", {31'h0, crc_err}, 32'h0);
      check_eq("start_ready", {31'h0, ser_ready}, 32'h1);
      check_eq("start_busy", {31'h0, busy}, 32'h1);
   endtask

   // Stream one frame. mode 0: valid held, 1: valid toggles (starts low),
   // 2: random valid + random start pulses, 3: valid held + start every other cycle.
   // Stops after abort_at transfers (40 for a full frame).
   task automatic run_frame(input logic [31:0] key, input logic [7:0] crc, input int mode,
                            input int abort_at, output int cycles, output int ready_cycles);
      logic [39:0] fr;
      logic        v;
      logic        xfer;
      int          idx;
      fr           = {key, crc};
      idx          = 0;
      cycles       = 0;
      ready_cycles = 0;
      while (idx < abort_at && cycles < 400) begin
         case (mode)
            0:       begin v = 1'b1;                          start = 1'b0;                           end
            1:       begin v = cycles[0];                     start = 1'b0;                           end
            2:       begin v = 1'($urandom_range(0, 1));      start = ($urandom_range(0, 5) == 0);    end
            default: begin v = 1'b1;                          start = cycles[0];                      end
         endcase
         ser_valid = v;
         ser_data  = v ? fr[39 - idx] : 1'($urandom_range(0, 1));
         check_eq("mid_key_hidden", key_out, 32'h0);
         if (ser_ready) ready_cycles++;
         xfer = v & ser_ready;
         tick();
         cycles++;
         if (xfer) idx++;
      end
      ser_valid = 1'b0;
      start     = 1'b0;
      check_eq("frame_transfers", idx, abort_at);
      check_eq("ready_every_cycle", ready_cycles, cycles);
   endtask

   // Called in the CHECK cycle; checks the verdict one cycle later and that it holds.
   task automatic post_frame(input logic [31:0] key, input logic [7:0] crc, input logic start_in_check);
      logic        good;
      logic [31:0] exp_key;
      good    = (ref_crc(key) == crc);
      exp_key = good ? key : 32'h0;
      check_eq("check_ready_low", {31'h0, ser_ready}, 32'h0);
      check_eq("check_busy", {31'h0, busy}, 32'h1);
      check_eq("check_valid_low", {31'h0, key_valid}, 32'h0);
      check_eq("check_key_hidden", key_out, 32'h0);
      start = start_in_check;
      tick();
      start = 1'b0;
      check_eq("res_key", key_out, exp_key);
      check_eq("res_valid", {31'h0, key_valid}, {31'h0, good});
      check_eq("res_crc_err", {31'h0, crc_err}, {31'h0, ~good});
      check_eq("res_busy", {31'h0, busy}, 32'h0);
      repeat (2) tick();
      check_eq("hold_key", key_out, exp_key);
      check_eq("hold_valid", {31'h0, key_valid}, {31'h0, good});
      check_eq("hold_crc_err", {31'h0, crc_err}, {31'h0, ~good});
      check_eq("hold_ready_low", {31'h0, ser_ready}, 32'h0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_key"}, key_out, 32'h0);
      check_eq({tag, "_valid"}, {31'h0, key_valid}, 32'h0);
      check_eq({tag, "_ready"}, {31'h0, ser_ready}, 32'h0);
      check_eq({tag, "_busy"}, {31'h0, busy}, 32'h0);
      check_eq({tag, "_err"}, {31'h0, crc_err}, 32'h0);
   endtask

   initial begin
      int          cyc;
      int          rdy;
      logic [31:0] rk;
      logic [7:0]  rc;
      err_cnt   = 0;
      chk_cnt   = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;

      // Reset with no start.
      repeat (3) tick();
      check_reset_vals("rst");
      rst_n = 1'b1;
      tick();
      check_reset_vals("idle");
      // Serial traffic while idle must be ignored.
      ser_valid = 1'b1;
      ser_data  = 1'b1;
      repeat (3) tick();
      ser_valid = 1'b0;
      check_reset_vals("idle_traffic");

      // Good frame, key 1, CRC 07, valid held high: 40 ready cycles.
      check_eq("ref_crc_key1", {24'h0, ref_crc(32'h0000_0001)}, 32'h07);
      do_start();
      run_frame(32'h0000_0001, 8'h07, 0, 40, cyc, rdy);
      check_eq("held_cycles", cyc, 40);
      check_eq("held_ready_cycles", rdy, 40);
      post_frame(32'h0000_0001, 8'h07, 1'b0);

      // Bad CRC -> ERROR, then a start clears crc_err.
      do_start();
      run_frame(32'h0000_0001, 8'h06, 0, 40, cyc, rdy);
      post_frame(32'h0000_0001, 8'h06, 1'b0);
      do_start();

      // Key 0 / CRC 0 with valid toggling: stalls must not advance the count.
      run_frame(32'h0000_0000, 8'h00, 1, 40, cyc, rdy);
      check_eq("toggle_cycles", cyc, 80);
      check_eq("toggle_ready_cycles", rdy, 80);
      post_frame(32'h0000_0000, 8'h00, 1'b0);

      // From DONE with key 1: start hides the key; starts during SHIFT/CHECK ignored.
      do_start();
      run_frame(32'h0000_0001, 8'h07, 0, 40, cyc, rdy);
      post_frame(32'h0000_0001, 8'h07, 1'b0);
      do_start();
      run_frame(32'hA5C3_0F96, ref_crc(32'hA5C3_0F96), 3, 40, cyc, rdy);
      check_eq("start_in_shift_cycles", cyc, 40);
      post_frame(32'hA5C3_0F96, ref_crc(32'hA5C3_0F96), 1'b1);

      // Reset after the 20th transfer, then a full good frame.
      do_start();
      run_frame(32'hDEAD_BEEF, ref_crc(32'hDEAD_BEEF), 0, 20, cyc, rdy);
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_vals("post_rst");
      do_start();
      run_frame(32'h1234_5678, ref_crc(32'h1234_5678), 0, 40, cyc, rdy);
      post_frame(32'h1234_5678, ref_crc(32'h1234_5678), 1'b0);

      // Randomized frames: random keys, mostly good CRCs, random stalls and starts.
      for (int n = 0; n < 30; n++) begin
         rk = $urandom;
         rc = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ref_crc(rk);
         do_start();
         run_frame(rk, rc, 2, 40, cyc, rdy);
         post_frame(rk, rc, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_rll_key_loader
